// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    HOLD    = 3'd3,
    DISCARD = 3'd4
  } fetch_state_t;

  localparam logic [31:0] PC_INC     = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Response timeout counter: counts enabled cycles and pulses expire on the
// last one, then restarts from zero.
module fetch_timeout_ctr #(
  parameter int TIMEOUT_CYC = 16,
  parameter int TO_W        = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    expire = enable && (cnt_q == LAST);
    cnt_d  = cnt_q;
    if (clear || expire) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a time,
// buffers the returned word for decode and applies execute-stage redirects.
// imem handshake: imem_req is held until imem_gnt; exactly one imem_rvalid
// follows each grant. Decode handshake: instr is transferred on a cycle where
// instr_valid and instr_ready are both high; instr/instr_pc hold until then.
module fetch_seq_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16,
  parameter int          TO_W        = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  output logic         instr_valid,
  output logic [31:0]  instr,
  output logic [31:0]  instr_pc,
  input  logic         instr_ready,
  input  logic         ex_valid,
  input  logic         is_branch,
  input  logic         is_jump,
  input  logic         br_true,
  input  logic [31:0]  target_addr,
  output logic         fetch_err,
  output logic         misalign_err,
  output fetch_state_t dbg_state
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         fetch_err_q, fetch_err_d;
  logic         misalign_err_q, misalign_err_d;

  logic redirect;
  logic waiting;
  logic to_clear;
  logic to_expire;

  assign redirect = ex_valid && (is_jump || (is_branch && br_true));
  assign waiting  = (state_q == WAIT) || (state_q == DISCARD);
  // WAIT -> DISCARD restarts the timeout window for the stale response.
  assign to_clear = !waiting || ((state_q == WAIT) && !imem_rvalid && redirect);

  fetch_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (to_clear),
    .enable(waiting && !imem_rvalid),
    .expire(to_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt) state_d = redirect ? DISCARD : WAIT;
      end
      WAIT: begin
        if (to_expire)        state_d = REQ;
        else if (imem_rvalid) state_d = redirect ? REQ : HOLD;
        else if (redirect)    state_d = DISCARD;
      end
      HOLD: begin
        if (redirect || instr_ready) state_d = REQ;
      end
      DISCARD: begin
        if (imem_rvalid || to_expire) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; a redirect overrides the PC in every state.
  always_comb begin
    pc_d           = pc_q;
    instr_valid_d  = instr_valid_q;
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    fetch_err_d    = to_expire;
    misalign_err_d = redirect && (target_addr[1:0] != 2'b00);
    if ((state_q == WAIT) && imem_rvalid && !redirect) begin
      instr_d       = imem_rdata;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
      pc_d          = pc_q + PC_INC;
    end
    if ((state_q == HOLD) && (redirect || instr_ready)) begin
      instr_valid_d = 1'b0;
    end
    if (redirect) begin
      pc_d = target_addr & ALIGN_MASK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      instr_valid_q  <= 1'b0;
      instr_q        <= '0;
      instr_pc_q     <= '0;
      fetch_err_q    <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      instr_valid_q  <= instr_valid_d;
      instr_q        <= instr_d;
      instr_pc_q     <= instr_pc_d;
      fetch_err_q    <= fetch_err_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  always_comb begin
    imem_req     = (state_q == REQ);
    imem_addr    = pc_q;
    instr_valid  = instr_valid_q;
    instr        = instr_q;
    instr_pc     = instr_pc_q;
    fetch_err    = fetch_err_q;
    misalign_err = misalign_err_q;
    dbg_state    = state_q;
  end

endmodule
